// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined fixed-point adder/subtractor.
//
// Both operands are aligned to a common signed format and added or subtracted
// at full precision. The result is then quantised by truncation or
// round-half-up and fitted to the output format by wrapping or saturating.
// A valid bit travels alongside each sample. LATENCY (1..3) selects where the
// pipeline registers sit:
//   1: add -> quantise -> format -> [out]
//   2: add -> [reg] -> quantise -> format -> [out]
//   3: add -> [reg] -> quantise -> [reg] -> format -> [out]
//
// Optional build macro: ADDSUB_OVF_COUNT_EN. When it is defined, the block
// contains a 16-bit saturating count of presented overflow samples. When it is
// not defined, ovf_count is tied to zero.
module addsub_pipe #(
  parameter int N_BITS_A              = 8,
  parameter int BIN_PT_A              = 4,
  parameter int SIGNED_A              = 1,
  parameter int N_BITS_B              = 8,
  parameter int BIN_PT_B              = 6,
  parameter int SIGNED_B              = 1,
  parameter int N_BITS_OUT            = 8,
  parameter int BIN_PT_OUT            = 4,
  parameter int SIGNED_OUT            = 1,
  parameter int OVERFLOW_STRATEGY     = 1,
  parameter int QUANTIZATION_STRATEGY = 1,
  parameter int LATENCY               = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic                  subtract,
  input  logic [N_BITS_A-1:0]   a,
  input  logic [N_BITS_B-1:0]   b,
  output logic [N_BITS_OUT-1:0] sum_out,
  output logic                  out_valid,
  output logic                  overflow,
  output logic [15:0]           ovf_count
);

  // Whole bits of each operand, including sign. An unsigned operand gets one
  // extra zero bit so that it stays non-negative once it is treated as signed.
  localparam int IA  = N_BITS_A - BIN_PT_A + ((SIGNED_A != 0) ? 0 : 1);
  localparam int IB  = N_BITS_B - BIN_PT_B + ((SIGNED_B != 0) ? 0 : 1);
  localparam int W   = (IA > IB) ? IA : IB;
  localparam int F   = (BIN_PT_A > BIN_PT_B) ? BIN_PT_A : BIN_PT_B;
  // One spare bit so that the add or subtract cannot overflow.
  localparam int FW  = W + F + 1;
  localparam int SHA = F - BIN_PT_A;
  localparam int SHB = F - BIN_PT_B;

  // Quantisation geometry. D > 0 drops LSBs. D <= 0 pads zero LSBs.
  localparam int D   = F - BIN_PT_OUT;
  localparam int PAD = (D < 0) ? -D : 0;
  localparam int SH  = (D > 0) ? D : 0;
  localparam int RSH = (D > 1) ? D - 1 : 0;

  // The quantised width has room for the rounding carry and any LSB padding.
  // It also has room for the output range limits plus a sign bit.
  localparam int QW0 = FW + 1 + PAD;
  localparam int QW  = (QW0 > N_BITS_OUT + 2) ? QW0 : N_BITS_OUT + 2;

  localparam logic signed [QW-1:0] HALF = (D > 0) ? (QW'(1) << RSH) : '0;
  localparam logic signed [QW-1:0] OUT_MAX = (SIGNED_OUT != 0) ?
      ((QW'(1) << (N_BITS_OUT - 1)) - QW'(1)) :
      ((QW'(1) << N_BITS_OUT) - QW'(1));
  localparam logic signed [QW-1:0] OUT_MIN = (SIGNED_OUT != 0) ?
      (~((QW'(1) << (N_BITS_OUT - 1)) - QW'(1))) : '0;

  // ---------------------------------------------------------------------------
  // Alignment and full-precision add/subtract
  // ---------------------------------------------------------------------------
  logic signed [FW-1:0] a_ext;
  logic signed [FW-1:0] b_ext;
  logic signed [FW-1:0] a_al;
  logic signed [FW-1:0] b_al;
  logic signed [FW-1:0] sum_d;
  logic                 add_vld_d;

  // Extend each operand by its own signedness, shift it to F fractional bits,
  // then combine the two.
  always_comb begin
    if (SIGNED_A != 0) a_ext = FW'($signed(a));
    else               a_ext = FW'($unsigned(a));
    if (SIGNED_B != 0) b_ext = FW'($signed(b));
    else               b_ext = FW'($unsigned(b));
    a_al      = a_ext <<< SHA;
    b_al      = b_ext <<< SHB;
    sum_d     = subtract ? (a_al - b_al) : (a_al + b_al);
    add_vld_d = in_valid;
  end

  // Full-precision sum, after the optional add-stage register.
  logic signed [FW-1:0] sum_s;
  logic                 sum_vld_s;

  generate
    if (LATENCY >= 2) begin : g_add_reg
      logic signed [FW-1:0] sum_q;
      logic                 add_vld_q;

      // Register the full-precision sum together with its valid bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q     <= '0;
          add_vld_q <= 1'b0;
        end else if (en) begin
          sum_q     <= sum_d;
          add_vld_q <= add_vld_d;
        end
      end

      assign sum_s     = sum_q;
      assign sum_vld_s = add_vld_q;
    end else begin : g_add_pass
      assign sum_s     = sum_d;
      assign sum_vld_s = add_vld_d;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Quantisation
  // ---------------------------------------------------------------------------
  logic signed [QW-1:0] quant_wide;
  logic signed [QW-1:0] quant_d;
  logic                 quant_vld_d;

  // Bring the sum to output LSBs. The arithmetic right shift gives floor
  // toward minus infinity. Rounding first adds half an output LSB, and the
  // extra width keeps that carry from wrapping.
  always_comb begin
    quant_wide = QW'(sum_s);
    if (D <= 0) begin
      quant_d = quant_wide <<< PAD;
    end else if (QUANTIZATION_STRATEGY != 0) begin
      quant_d = (quant_wide + HALF) >>> SH;
    end else begin
      quant_d = quant_wide >>> SH;
    end
    quant_vld_d = sum_vld_s;
  end

  // Quantised value, after the optional quantise-stage register.
  logic signed [QW-1:0] quant_s;
  logic                 quant_vld_s;

  generate
    if (LATENCY >= 3) begin : g_quant_reg
      logic signed [QW-1:0] quant_q;
      logic                 quant_vld_q;

      // Register the quantised value together with its valid bit.
      always_ff @(posedge clk) begin
        if (rst) begin
          quant_q     <= '0;
          quant_vld_q <= 1'b0;
        end else if (en) begin
          quant_q     <= quant_d;
          quant_vld_q <= quant_vld_d;
        end
      end

      assign quant_s     = quant_q;
      assign quant_vld_s = quant_vld_q;
    end else begin : g_quant_pass
      assign quant_s     = quant_d;
      assign quant_vld_s = quant_vld_d;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Range check, wrap/saturate, output register
  // ---------------------------------------------------------------------------
  logic [N_BITS_OUT-1:0] sum_out_d;
  logic                  overflow_d;
  logic                  out_valid_d;

  // Flag values outside the output range. Wrap keeps the low bits. Saturate
  // clamps to the nearest limit. The flag is suppressed for bubbles.
  always_comb begin
    sum_out_d   = quant_s[N_BITS_OUT-1:0];
    overflow_d  = 1'b0;
    out_valid_d = quant_vld_s;
    if (quant_s > OUT_MAX) begin
      overflow_d = 1'b1;
      if (OVERFLOW_STRATEGY != 0) sum_out_d = OUT_MAX[N_BITS_OUT-1:0];
    end else if (quant_s < OUT_MIN) begin
      overflow_d = 1'b1;
      if (OVERFLOW_STRATEGY != 0) sum_out_d = OUT_MIN[N_BITS_OUT-1:0];
    end
    if (!quant_vld_s) overflow_d = 1'b0;
  end

  logic [N_BITS_OUT-1:0] sum_out_q;
  logic                  overflow_q;
  logic                  out_valid_q;

  // Output register. Every stage freezes while en is low. Reset clears the
  // stage whether or not en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      sum_out_q   <= sum_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum_out   = sum_out_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

  // ---------------------------------------------------------------------------
  // Optional overflow event counter
  // ---------------------------------------------------------------------------
`ifdef ADDSUB_OVF_COUNT_EN
  logic [15:0] ovf_count_q;
  logic [15:0] ovf_count_d;

  // Count one event for each enabled cycle that presents an overflowing
  // sample. The count sticks at all ones.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (en && out_valid_q && overflow_q && (ovf_count_q != 16'hFFFF)) begin
      ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) ovf_count_q <= '0;
    else     ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed testbench for addsub_pipe. It runs five instances side by side:
//   0 def : default parameters
//   1 wt  : wrap + truncate
//   2 uns : unsigned a, unsigned output
//   3 l1  : LATENCY = 1
//   4 l3  : LATENCY = 3
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic in_valid;
  logic subtract;
  logic [7:0] a_i;
  logic [7:0] b_i;

  logic [4:0][7:0]  o_sum;
  logic [4:0]       o_vld;
  logic [4:0]       o_ovf;
  logic [4:0][15:0] o_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cap_sum [5][4];
  logic       cap_vld [5][4];
  logic       cap_ovf [5][4];

  string dn [5] = '{"def", "wt", "uns", "l1", "l3"};

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] s0;
    logic       o0;
    logic [7:0] s1;
    logic       o1;
    logic [7:0] s2;
    logic       o2;
  } vec_t;

  always #5 clk = ~clk;

  addsub_pipe u_def (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .subtract(subtract),
    .a(a_i), .b(b_i), .sum_out(o_sum[0]), .out_valid(o_vld[0]),
    .overflow(o_ovf[0]), .ovf_count(o_cnt[0])
  );

  addsub_pipe #(.OVERFLOW_STRATEGY(0), .QUANTIZATION_STRATEGY(0)) u_wt (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .subtract(subtract),
    .a(a_i), .b(b_i), .sum_out(o_sum[1]), .out_valid(o_vld[1]),
    .overflow(o_ovf[1]), .ovf_count(o_cnt[1])
  );

  addsub_pipe #(.SIGNED_A(0), .SIGNED_OUT(0)) u_uns (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .subtract(subtract),
    .a(a_i), .b(b_i), .sum_out(o_sum[2]), .out_valid(o_vld[2]),
    .overflow(o_ovf[2]), .ovf_count(o_cnt[2])
  );

  addsub_pipe #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .subtract(subtract),
    .a(a_i), .b(b_i), .sum_out(o_sum[3]), .out_valid(o_vld[3]),
    .overflow(o_ovf[3]), .ovf_count(o_cnt[3])
  );

  addsub_pipe #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .subtract(subtract),
    .a(a_i), .b(b_i), .sum_out(o_sum[4]), .out_valid(o_vld[4]),
    .overflow(o_ovf[4]), .ovf_count(o_cnt[4])
  );

  // Record every instance's outputs for cycle k after issue.
  task automatic capture(input int k);
    for (int d = 0; d < 5; d++) begin
      cap_sum[d][k] = o_sum[d];
      cap_vld[d][k] = o_vld[d];
      cap_ovf[d][k] = o_ovf[d];
    end
  endtask

  // Issue one sample, capture cycles 1..3 after it, then idle for one cycle.
  task automatic run_sample(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    a_i = av;
    b_i = bv;
    subtract = sv;
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      capture(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b1;
    a_i = 8'h7F;
    b_i = 8'h7F;
    subtract = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (o_vld[d] !== 1'b0 || o_ovf[d] !== 1'b0 || o_sum[d] !== 8'h00 || o_cnt[d] !== 16'h0) begin
        failures++;
        $display("FAIL reset %s got vld=%0b ovf=%0b sum=%02h cnt=%0d exp all zero",
                 dn[d], o_vld[d], o_ovf[d], o_sum[d], o_cnt[d]);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    $display("reset: outputs checked while rst held");
  endtask

  task automatic test_basic();
    vec_t v [3];
    v[0] = '{8'h10, 8'h40, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0};
    v[1] = '{8'h30, 8'hC0, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0};
    v[2] = '{8'h08, 8'h10, 1'b0, 8'h0C, 1'b0, 8'h0C, 1'b0, 8'h0C, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_sample(v[i].a, v[i].b, v[i].sub);
      for (int d = 0; d < 5; d++) begin
        int lat;
        logic [7:0] es;
        logic eo;
        lat = (d == 3) ? 1 : ((d == 4) ? 3 : 2);
        es  = (d == 1) ? v[i].s1 : ((d == 2) ? v[i].s2 : v[i].s0);
        eo  = (d == 1) ? v[i].o1 : ((d == 2) ? v[i].o2 : v[i].o0);
        for (int k = 1; k <= 3; k++) begin
          checks++;
          if (cap_vld[d][k] !== (k == lat) || (k != lat && cap_ovf[d][k] !== 1'b0)) begin
            failures++;
            $display("FAIL basic_timing vec%0d %s cyc%0d got vld=%0b ovf=%0b exp vld=%0b", i, dn[d], k, cap_vld[d][k], cap_ovf[d][k], (k == lat));
          end
        end
        checks++;
        if (cap_sum[d][lat] !== es || cap_ovf[d][lat] !== eo) begin
          failures++;
          $display("FAIL basic vec%0d %s got sum=%02h ovf=%0b exp sum=%02h ovf=%0b", i, dn[d], cap_sum[d][lat], cap_ovf[d][lat], es, eo);
        end
      end
      $display("basic: a=%02h b=%02h sub=%0b def sum=%02h ovf=%0b", v[i].a, v[i].b, v[i].sub, cap_sum[0][2], cap_ovf[0][2]);
    end
  endtask

  task automatic test_overflow();
    vec_t v [3];
    v[0] = '{8'h7F, 8'h7F, 1'b0, 8'h7F, 1'b1, 8'h9E, 1'b1, 8'h9F, 1'b0};
    v[1] = '{8'hFF, 8'h7F, 1'b0, 8'h1F, 1'b0, 8'h1E, 1'b0, 8'hFF, 1'b1};
    v[2] = '{8'h70, 8'h40, 1'b0, 8'h7F, 1'b1, 8'h80, 1'b1, 8'h80, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_sample(v[i].a, v[i].b, v[i].sub);
      for (int d = 0; d < 5; d++) begin
        int lat;
        logic [7:0] es;
        logic eo;
        lat = (d == 3) ? 1 : ((d == 4) ? 3 : 2);
        es  = (d == 1) ? v[i].s1 : ((d == 2) ? v[i].s2 : v[i].s0);
        eo  = (d == 1) ? v[i].o1 : ((d == 2) ? v[i].o2 : v[i].o0);
        for (int k = 1; k <= 3; k++) begin
          checks++;
          if (cap_vld[d][k] !== (k == lat) || (k != lat && cap_ovf[d][k] !== 1'b0)) begin
            failures++;
            $display("FAIL overflow_timing vec%0d %s cyc%0d got vld=%0b ovf=%0b exp vld=%0b", i, dn[d], k, cap_vld[d][k], cap_ovf[d][k], (k == lat));
          end
        end
        checks++;
        if (cap_sum[d][lat] !== es || cap_ovf[d][lat] !== eo) begin
          failures++;
          $display("FAIL overflow vec%0d %s got sum=%02h ovf=%0b exp sum=%02h ovf=%0b", i, dn[d], cap_sum[d][lat], cap_ovf[d][lat], es, eo);
        end
      end
      $display("overflow: a=%02h b=%02h def sum=%02h ovf=%0b", v[i].a, v[i].b, cap_sum[0][2], cap_ovf[0][2]);
    end
  endtask

  task automatic test_quantise();
    vec_t v [4];
    v[0] = '{8'h00, 8'h02, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    v[1] = '{8'h00, 8'hFE, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0};
    v[2] = '{8'h00, 8'h03, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};
    v[3] = '{8'h00, 8'hFA, 1'b0, 8'hFF, 1'b0, 8'hFE, 1'b0, 8'h00, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_sample(v[i].a, v[i].b, v[i].sub);
      for (int d = 0; d < 5; d++) begin
        int lat;
        logic [7:0] es;
        logic eo;
        lat = (d == 3) ? 1 : ((d == 4) ? 3 : 2);
        es  = (d == 1) ? v[i].s1 : ((d == 2) ? v[i].s2 : v[i].s0);
        eo  = (d == 1) ? v[i].o1 : ((d == 2) ? v[i].o2 : v[i].o0);
        for (int k = 1; k <= 3; k++) begin
          checks++;
          if (cap_vld[d][k] !== (k == lat) || (k != lat && cap_ovf[d][k] !== 1'b0)) begin
            failures++;
            $display("FAIL quant_timing vec%0d %s cyc%0d got vld=%0b ovf=%0b exp vld=%0b", i, dn[d], k, cap_vld[d][k], cap_ovf[d][k], (k == lat));
          end
        end
        checks++;
        if (cap_sum[d][lat] !== es || cap_ovf[d][lat] !== eo) begin
          failures++;
          $display("FAIL quant vec%0d %s got sum=%02h ovf=%0b exp sum=%02h ovf=%0b", i, dn[d], cap_sum[d][lat], cap_ovf[d][lat], es, eo);
        end
      end
      $display("quant: a=%02h b=%02h def sum=%02h wt sum=%02h", v[i].a, v[i].b, cap_sum[0][2], cap_sum[1][2]);
    end
  endtask

  task automatic test_subtract();
    vec_t v [3];
    v[0] = '{8'h80, 8'h40, 1'b1, 8'h80, 1'b1, 8'h70, 1'b1, 8'h70, 1'b0};
    v[1] = '{8'h00, 8'h40, 1'b1, 8'hF0, 1'b0, 8'hF0, 1'b0, 8'h00, 1'b1};
    v[2] = '{8'h20, 8'hC0, 1'b1, 8'h30, 1'b0, 8'h30, 1'b0, 8'h30, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_sample(v[i].a, v[i].b, v[i].sub);
      for (int d = 0; d < 5; d++) begin
        int lat;
        logic [7:0] es;
        logic eo;
        lat = (d == 3) ? 1 : ((d == 4) ? 3 : 2);
        es  = (d == 1) ? v[i].s1 : ((d == 2) ? v[i].s2 : v[i].s0);
        eo  = (d == 1) ? v[i].o1 : ((d == 2) ? v[i].o2 : v[i].o0);
        for (int k = 1; k <= 3; k++) begin
          checks++;
          if (cap_vld[d][k] !== (k == lat) || (k != lat && cap_ovf[d][k] !== 1'b0)) begin
            failures++;
            $display("FAIL sub_timing vec%0d %s cyc%0d got vld=%0b ovf=%0b exp vld=%0b", i, dn[d], k, cap_vld[d][k], cap_ovf[d][k], (k == lat));
          end
        end
        checks++;
        if (cap_sum[d][lat] !== es || cap_ovf[d][lat] !== eo) begin
          failures++;
          $display("FAIL sub vec%0d %s got sum=%02h ovf=%0b exp sum=%02h ovf=%0b", i, dn[d], cap_sum[d][lat], cap_ovf[d][lat], es, eo);
        end
      end
      $display("sub: a=%02h b=%02h def sum=%02h uns sum=%02h", v[i].a, v[i].b, cap_sum[0][2], cap_sum[2][2]);
    end
  endtask

  // Six samples stream back to back while en drops for three cycles mid-stream.
  // Junk presented during those cycles must be ignored.
  task automatic test_back_to_back();
    logic [7:0] got0 [$];
    logic [7:0] got4 [$];
    logic [7:0] snap_sum0, snap_sum4;
    logic       snap_vld0, snap_vld4;
    int sent;
    bit en_now;
    sent = 0;
    for (int c = 0; c < 14; c++) begin
      en_now = !(c >= 3 && c <= 5);
      en = en_now;
      subtract = 1'b0;
      if (!en_now) begin
        in_valid = 1'b1;
        a_i = 8'h55;
        b_i = 8'h11;
      end else if (sent < 6) begin
        in_valid = 1'b1;
        a_i = 8'((sent + 1) * 16);
        b_i = 8'h40;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      snap_sum0 = o_sum[0];
      snap_vld0 = o_vld[0];
      snap_sum4 = o_sum[4];
      snap_vld4 = o_vld[4];
      @(posedge clk);
      #1;
      if (!en_now) begin
        checks++;
        if (o_vld[0] !== snap_vld0 || o_sum[0] !== snap_sum0 || o_vld[4] !== snap_vld4 || o_sum[4] !== snap_sum4) begin
          failures++;
          $display("FAIL b2b_frozen cyc%0d got def %0b/%02h l3 %0b/%02h exp def %0b/%02h l3 %0b/%02h",
                   c, o_vld[0], o_sum[0], o_vld[4], o_sum[4], snap_vld0, snap_sum0, snap_vld4, snap_sum4);
        end
      end else begin
        if (o_vld[0]) got0.push_back(o_sum[0]);
        if (o_vld[4]) got4.push_back(o_sum[4]);
      end
    end
    en = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (got0.size() != 6 || got4.size() != 6) begin
      failures++;
      $display("FAIL b2b_count got def=%0d l3=%0d exp 6", got0.size(), got4.size());
    end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] es;
      es = 8'((i + 2) * 16);
      checks++;
      if (i >= got0.size() || i >= got4.size() || got0[i] !== es || got4[i] !== es) begin
        failures++;
        $display("FAIL b2b_order idx%0d got def=%02h l3=%02h exp=%02h", i,
                 (i < got0.size()) ? got0[i] : 8'hXX, (i < got4.size()) ? got4[i] : 8'hXX, es);
      end
    end
    $display("b2b: collected def=%0d l3=%0d results", got0.size(), got4.size());
  endtask

  // A reset with en low lands in the middle of a stream and must flush it.
  task automatic test_reset_midstream();
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_i = 8'h10;
      b_i = 8'h40;
      subtract = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (o_vld[d] !== 1'b0 || o_ovf[d] !== 1'b0 || o_sum[d] !== 8'h00 || o_cnt[d] !== 16'h0) begin
        failures++;
        $display("FAIL mid_reset %s got vld=%0b ovf=%0b sum=%02h cnt=%0d exp all zero",
                 dn[d], o_vld[d], o_ovf[d], o_sum[d], o_cnt[d]);
      end
    end
    rst = 1'b0;
    en = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (o_vld !== 5'b0) begin
        failures++;
        $display("FAIL mid_reset_stale cyc%0d got out_valid=%05b exp 00000", c, o_vld);
      end
    end
    $display("mid_reset: pipeline flushed");
  endtask

  // Ten samples, five of which overflow on the default instance.
  task automatic test_ovf_count();
    int exp_cnt [5];
`ifdef ADDSUB_OVF_COUNT_EN
    exp_cnt = '{5, 5, 0, 5, 5};
`else
    exp_cnt = '{0, 0, 0, 0, 0};
`endif
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a_i = (i % 2 == 0) ? 8'h7F : 8'h10;
      b_i = (i % 2 == 0) ? 8'h7F : 8'h40;
      subtract = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (o_cnt[d] !== 16'(exp_cnt[d])) begin
        failures++;
        $display("FAIL ovf_count %s got=%0d exp=%0d", dn[d], o_cnt[d], exp_cnt[d]);
      end
    end
    $display("ovf_count: def=%0d wt=%0d uns=%0d l1=%0d l3=%0d", o_cnt[0], o_cnt[1], o_cnt[2], o_cnt[3], o_cnt[4]);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    subtract = 1'b0;
    a_i = 8'h00;
    b_i = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_quantise();
    test_subtract();
    test_back_to_back();
    test_reset_midstream();
    test_ovf_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Pipelined fixed-point adder/subtractor with selectable quantisation (truncate/round) and overflow handling (wrap/saturate). It produces results in a caller-specified output format, with a valid strobe and a per-sample overflow flag. It is the general arithmetic primitive for datapaths that need a registered, formatted sum or difference instead of a full-precision combinational one.

## Interface
- N_BITS_A, 8, width of a
- BIN_PT_A, 4, fractional bits of a
- SIGNED_A, 1, 1 = a two's complement, 0 = unsigned
- N_BITS_B, 8, width of b
- BIN_PT_B, 6, fractional bits of b
- SIGNED_B, 1, 1 = b two's complement, 0 = unsigned
- N_BITS_OUT, 8, result width
- BIN_PT_OUT, 4, result fractional bits
- SIGNED_OUT, 1, 1 = signed result, 0 = unsigned
- OVERFLOW_STRATEGY, 1, 0 = wrap, 1 = saturate
- QUANTIZATION_STRATEGY, 1, 0 = truncate, 1 = round half up
- LATENCY, 2, pipeline depth, legal 1..3
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable; low freezes every pipeline register
- in_valid  input  1  a/b/subtract qualify this cycle
- subtract  input  1  0 = a+b, 1 = a−b
- a  input  N_BITS_A  operand a
- b  input  N_BITS_B  operand b
- sum_out  output  N_BITS_OUT  formatted result
- out_valid  output  1  sum_out/overflow valid
- overflow  output  1  result exceeded output range (either strategy)
- ovf_count  output  16  saturating overflow event count (see Configuration)

## Operation
- Align: unsigned operands zero-extended by one whole bit; both sign-extended to W = max(whole bits) and shifted to F = max(BIN_PT_A, BIN_PT_B) fractional bits.
- Full result: signed, W+F+1 bits; a+b or a−b by `subtract`.
- Quantise with D = F − BIN_PT_OUT:
  - D ≤ 0: zero-pad LSBs.
  - Truncate: drop D LSBs, i.e. floor toward −∞.
  - Round: add 2^(D−1), then drop. Computed one bit wider so rounding carry cannot wrap.
- Overflow: the quantised value is outside the output range (signed: [−2^(N−1), 2^(N−1)−1]; unsigned: [0, 2^N−1] in output LSBs) → overflow=1.
  - Wrap: output the low N_BITS_OUT bits.
  - Saturate: clamp to max or min. Unsigned output clamps negatives to 0.
- Pipeline stage placement by LATENCY:
  - 1: all arithmetic before a single output register.
  - 2: register after add; quantise+overflow before output register.
  - 3: register after add, after quantise, and at output.
- A valid bit travels with the data. Invalid slots propagate as bubbles with data don't-care. Overflow is forced to 0 when the slot is invalid.

## Timing
- Latency: exactly LATENCY enabled cycles from in_valid to out_valid. Throughput is one sample per enabled cycle.
- en=0: all registers, including valid bits, hold. Outputs stay stable. Inputs are ignored.
- rst=1, regardless of en: all valid bits, sum_out, overflow and ovf_count are cleared to 0 on that edge. In-flight samples are discarded.
- First input after reset is accepted the cycle rst deasserts.
- No backpressure. The consumer must accept out_valid when it is presented.

## Configuration
- ADDSUB_OVF_COUNT_EN defined:
  - ovf_count increments by 1 on each cycle where out_valid & overflow, with en high.
  - It saturates at 0xFFFF and clears on rst.
- Undefined: the counter logic is absent and ovf_count is tied to 0.

## Test plan
- Defaults, a=0x10 (1.0), b=0x40 (1.0), subtract=0, in_valid=1 → exactly 2 cycles later out_valid=1, sum_out=0x20, overflow=0.
- Defaults, a=0x7F, b=0x7F → sum_out=0x7F, overflow=1. With OVERFLOW_STRATEGY=0 → sum_out=0x9F, overflow=1.
- Defaults, a=0x00, b=0x02 (half output LSB) → sum_out=0x01. With QUANTIZATION_STRATEGY=0 → 0x00. With a=0x00, b=0xFE (−0.03125), truncate → 0xFF.
- a=0x80 (−8.0), b=0x40, subtract=1 → sum_out=0x80, overflow=1. With SIGNED_OUT=0 and a=0x00, b=0x40, subtract=1 → sum_out=0x00, overflow=1.
- Back-to-back valids with en low for 3 cycles mid-stream → outputs frozen, order preserved, no drops or duplicates. rst pulse mid-stream → out_valid=0 next cycle, no stale results emerge.
- ADDSUB_OVF_COUNT_EN, 5 overflowing samples among 10 → ovf_count=5. Sweep LATENCY=1,3 → same values with 1- and 3-cycle latency.
